// File: rtl/mmio_io_responder.sv
// MMIO responder for the 0xFFFFFCxx I/O page: switches, button, LEDs, 7-seg.
// Optional 7-seg scanning under `SEG7_EN; ports are listed on the module.
module mmio_io_responder #(
  parameter int DB_CYCLES = 20000,
  parameter int SCAN_DIV  = 100000
) (
  input  logic        clock,    // system clock
  input  logic        rst_n,    // async active-low reset
  input  logic        io_read,  // load to I/O space
  input  logic        io_write, // store to I/O space
  input  logic [9:0]  addr,     // byte offset in I/O page
  input  logic [31:0] wdata,    // store data
  output logic [31:0] rdata,    // load data
  input  logic [23:0] switch_i, // raw switches
  input  logic        btn_i,    // raw button
  output logic [23:0] led_o,    // LED register
  output logic [7:0]  seg_an_o, // digit enables, active-low
  output logic [7:0]  seg_ca_o  // segments {dp,g..a}, active-low
);

  localparam int DBW = $clog2(DB_CYCLES);
  // The load happens on the increment that would reach DB_CYCLES-1,
  // giving an accept latency of 2 + DB_CYCLES cycles.
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 2);

  logic [23:0]    r_led;
  logic [23:0]    r_sw_s1, r_sw_s2, r_sw_last, r_sw_db;
  logic [DBW-1:0] r_sw_cnt;
  logic           r_btn_s1, r_btn_s2, r_btn_last, r_btn_db;
  logic [DBW-1:0] r_btn_cnt;
  logic           r_btn_flag;

  logic w_sel_led, w_sel_sw, w_sel_flag, w_sel_lvl, w_sel_seg;
  logic w_sw_ld, w_btn_ld, w_btn_rise, w_flag_clr;

  assign w_sel_led  = (addr == 10'h060);
  assign w_sel_sw   = (addr == 10'h070);
  assign w_sel_flag = (addr == 10'h074);
  assign w_sel_lvl  = (addr == 10'h078);

  assign w_sw_ld = (r_sw_s2 == r_sw_last) &&
                   (r_sw_s2 != r_sw_db) &&
                   (r_sw_cnt == DB_LAST);
  assign w_btn_ld = (r_btn_s2 == r_btn_last) &&
                    (r_btn_s2 != r_btn_db) &&
                    (r_btn_cnt == DB_LAST);
  assign w_btn_rise = w_btn_ld && r_btn_s2;
  assign w_flag_clr = io_read && w_sel_flag;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_sw_last <= '0;
      r_sw_db   <= '0;
      r_sw_cnt  <= '0;
    end else begin
      r_sw_s1   <= switch_i;
      r_sw_s2   <= r_sw_s1;
      r_sw_last <= r_sw_s2;
      if (r_sw_s2 != r_sw_last ||
          r_sw_s2 == r_sw_db) begin
        r_sw_cnt <= '0;
      end else if (w_sw_ld) begin
        r_sw_db  <= r_sw_s2;
        r_sw_cnt <= '0;
      end else begin
        r_sw_cnt <= r_sw_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_btn_last <= 1'b0;
      r_btn_db   <= 1'b0;
      r_btn_cnt  <= '0;
    end else begin
      r_btn_s1   <= btn_i;
      r_btn_s2   <= r_btn_s1;
      r_btn_last <= r_btn_s2;
      if (r_btn_s2 != r_btn_last ||
          r_btn_s2 == r_btn_db) begin
        r_btn_cnt <= '0;
      end else if (w_btn_ld) begin
        r_btn_db  <= r_btn_s2;
        r_btn_cnt <= '0;
      end else begin
        r_btn_cnt <= r_btn_cnt + 1'b1;
      end
    end
  end

  // A press landing on the clearing read keeps the flag set.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_flag <= 1'b0;
    end else if (w_btn_rise) begin
      r_btn_flag <= 1'b1;
    end else if (w_flag_clr) begin
      r_btn_flag <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else if (io_write && w_sel_led) begin
      r_led <= wdata[23:0];
    end
  end

  assign led_o = r_led;

`ifdef SEG7_EN
  localparam int SCW = $clog2(SCAN_DIV);
  localparam logic [SCW-1:0] SCAN_LAST =
    SCW'(SCAN_DIV - 1);

  logic [31:0]    r_seg;
  logic [SCW-1:0] r_scan;
  logic [2:0]     r_idx;
  logic [3:0]     w_nib;

  assign w_sel_seg = (addr == 10'h080);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '0;
    end else if (io_write && w_sel_seg) begin
      r_seg <= wdata;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_idx  <= r_idx + 1'b1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  assign w_nib    = r_seg[{r_idx, 2'b00} +: 4];
  assign seg_an_o = ~(8'b1 << r_idx);

  always_comb begin
    seg_ca_o = 8'hFF;
    unique case (w_nib)
      4'h0: seg_ca_o = 8'hC0;
      4'h1: seg_ca_o = 8'hF9;
      4'h2: seg_ca_o = 8'hA4;
      4'h3: seg_ca_o = 8'hB0;
      4'h4: seg_ca_o = 8'h99;
      4'h5: seg_ca_o = 8'h92;
      4'h6: seg_ca_o = 8'h82;
      4'h7: seg_ca_o = 8'hF8;
      4'h8: seg_ca_o = 8'h80;
      4'h9: seg_ca_o = 8'h90;
      4'hA: seg_ca_o = 8'h88;
      4'hB: seg_ca_o = 8'h83;
      4'hC: seg_ca_o = 8'hC6;
      4'hD: seg_ca_o = 8'hA1;
      4'hE: seg_ca_o = 8'h86;
      4'hF: seg_ca_o = 8'h8E;
    endcase
  end
`else
  logic w_unused;

  assign w_sel_seg = 1'b0;
  assign w_unused  = &{1'b0, wdata[31:24]};
  assign seg_an_o  = 8'hFF;
  assign seg_ca_o  = 8'hFF;
`endif

  always_comb begin
    rdata = '0;
    if (io_read) begin
      unique case (1'b1)
        w_sel_led:  rdata = {8'b0, r_led};
        w_sel_sw:   rdata = {8'b0, r_sw_db};
        w_sel_flag: rdata = {31'b0, r_btn_flag};
        w_sel_lvl:  rdata = {31'b0, r_btn_db};
`ifdef SEG7_EN
        w_sel_seg:  rdata = r_seg;
`else
        w_sel_seg:  rdata = '0;
`endif
        default:    rdata = '0;
      endcase
    end
  end

endmodule
